// File: rtl/interrupt_controller.sv
// 8-line edge-triggered interrupt controller with mask, priority select and IDLE/REQ/SERVICE handshake.
// Optional IRQ_SYNC_EN: adds a 2-flop input synchronizer ahead of edge detection.
module interrupt_controller #(
  parameter int NUM_IRQ        = 8,
  parameter bit PRIO_LOW_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               arst,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [NUM_IRQ-1:0] z_bus,
  input  logic               ctrl_irq_masks_wrt,
  input  logic               ctrl_int_ack,
  input  logic               ctrl_clear_all_ints,
  input  logic               int_eoi,
  input  logic               irq_en,
  output logic               int_pending,
  output logic [2:0]         int_vector_idx,
  output logic               int_in_service,
  output logic [NUM_IRQ-1:0] irq_pending_status,
  output logic [NUM_IRQ-1:0] irq_masks
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] masks_q, masks_d;
  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [2:0]         idx_q, idx_d;
  logic [NUM_IRQ-1:0] irq_s;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] req;
  logic               any_req;
  logic               take_ack;
  logic [2:0]         sel;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign rise    = irq_s & ~irq_prev_q;
  assign req     = pending_q & masks_q;
  assign any_req = (|req) & irq_en;

  // Later loop iterations overwrite earlier ones, so scan order sets the winner.
  always_comb begin
    sel = 3'd0;
    if (PRIO_LOW_FIRST) begin
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
        if (req[i]) sel = i[2:0];
      end
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (req[i]) sel = i[2:0];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    take_ack = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ctrl_clear_all_ints) begin
          state_d = ST_IDLE;
        end else if (ctrl_int_ack && any_req) begin
          state_d  = ST_SERVICE;
          idx_d    = sel;
          take_ack = 1'b1;
        end else if (!any_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (int_eoi) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A same-cycle edge re-arms the line being acked; clear-all beats both.
  always_comb begin
    pending_d = pending_q;
    if (take_ack) pending_d[sel] = 1'b0;
    pending_d = pending_d | rise;
    if (ctrl_clear_all_ints) pending_d = '0;
  end

  assign masks_d = ctrl_irq_masks_wrt ? z_bus : masks_q;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q    <= ST_IDLE;
      pending_q  <= '0;
      masks_q    <= '0;
      irq_prev_q <= '0;
      idx_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      masks_q    <= masks_d;
      irq_prev_q <= irq_s;
      idx_q      <= idx_d;
    end
  end

  assign int_pending        = (state_q == ST_REQ);
  assign int_in_service     = (state_q == ST_SERVICE);
  assign int_vector_idx     = idx_q;
  assign irq_pending_status = pending_q;
  assign irq_masks          = masks_q;

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Collects 8 external IRQ lines and latches rising edges as pending requests.
- Gates pending requests with a mask register written from z_bus.
- Priority-encodes the enabled requests and drives int_pending into microcode_sequencer, which uses it as its trap condition.
- Runs the IDLE/REQ/SERVICE handshake with the microcode via ctrl_int_ack and int_eoi, and exposes the serviced vector index for the trap microroutine.

Parameters:
NUM_IRQ, 8, number of IRQ lines; fixed at 8, matching the 8-bit z_bus mask write.
PRIO_LOW_FIRST, 1, 1 = irq 0 highest priority; 0 = irq 7 highest.

Ports:
clk  input  1  system clock
arst  input  1  asynchronous reset, active-high
irq_in  input  8  external interrupt lines, rising-edge triggered
z_bus  input  8  data source for mask writes
ctrl_irq_masks_wrt  input  1  load mask register from z_bus (1 = enable line)
ctrl_int_ack  input  1  microcode acknowledges the current request
ctrl_clear_all_ints  input  1  clear all pending bits
int_eoi  input  1  microcode end-of-interrupt (end of the return routine)
irq_en  input  1  global enable, taken from the cpu_status interrupt-enable bit
int_pending  output  1  registered request to the sequencer
int_vector_idx  output  3  index of the line being serviced, valid in SERVICE
int_in_service  output  1  high in SERVICE
irq_pending_status  output  8  raw pending register, for software read
irq_masks  output  8  current mask register

Behaviour:
- Reset values (arst=1, immediate): pending=0x00, irq_masks=0x00, irq_prev=0x00, state=IDLE, int_pending=0, int_vector_idx=0, int_in_service=0.
- Edge detection:
  - irq_prev <= irq_in every cycle.
  - pending[i] is set when irq_in[i]=1 and irq_prev[i]=0 at a clock edge.
  - Setting is independent of the mask: masked edges are still recorded.
- Request vector: req = pending & irq_masks. any_req = |req & irq_en.
- Priority: sel = lowest set index of req when PRIO_LOW_FIRST=1, otherwise the highest set index. sel is combinational.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE -> REQ when any_req=1.
  - REQ -> SERVICE on ctrl_int_ack=1 while any_req=1. On that edge:
    - int_vector_idx <= sel.
    - pending[sel] <= 0, unless a new edge on that line arrives in the same cycle; the set wins.
  - REQ -> IDLE when any_req=0 (request masked, cleared or irq_en dropped) without an ack.
  - SERVICE -> IDLE on int_eoi=1.
  - ctrl_int_ack outside REQ, and int_eoi outside SERVICE, are ignored.
- Outputs:
  - int_pending = (state==REQ), registered.
  - int_in_service = (state==SERVICE).
  - No nesting: new requests accumulate in pending during SERVICE and are raised after EOI.
- ctrl_clear_all_ints:
  - pending <= 0x00. This overrides a same-cycle edge set and the ack clear.
  - From REQ, the FSM returns to IDLE on the next edge.
  - It does not leave SERVICE.
- Mask write: irq_masks <= z_bus on ctrl_irq_masks_wrt.
  - The new mask takes effect for any_req on the cycle after the write.
  - Same-cycle write and ack: the ack uses the old mask.
- Latency: irq edge sampled at edge k -> pending set after k -> int_pending=1 after edge k+1, provided line enabled and irq_en=1.
  - Ack at edge m -> int_pending=0 and int_in_service=1 after m.
- A line held high sets pending only once; it must go low for at least 1 cycle to re-trigger.

Optional Feature:
IRQ_SYNC_EN
- Defined: irq_in passes through a 2-flop synchronizer (reset 0) ahead of edge detection. Edge-to-int_pending latency is 4 cycles.
- Undefined: irq_in is used directly (assumed synchronous to clk). Latency is 2 cycles.
- All other behaviour is identical.

Test Plan:
- Reset, write mask 0xFF, pulse irq_in[3] for 1 cycle -> pending=0x08 and int_pending=1 two cycles after the edge. Ack -> int_vector_idx=3, pending=0x00, int_in_service=1. int_eoi -> IDLE, int_pending stays 0.
- Mask 0xFF, edges on irq 2 and 5 in the same cycle, PRIO_LOW_FIRST=1 -> first ack gives idx 2, pending=0x20. After EOI, int_pending re-asserts; second ack gives idx 5.
- Mask 0x00, pulse irq 6 -> pending=0x40, int_pending stays 0. Write mask 0x40 -> int_pending=1 two cycles after the write cycle.
- In REQ with pending=0x01, assert ctrl_clear_all_ints -> pending=0x00, state IDLE, int_pending=0. A same-cycle new edge on irq 4 is also discarded.
- In SERVICE, new edge on irq 1 -> int_pending stays 0 until int_eoi. One cycle after EOI, state=REQ; int_pending=1.
- Assert arst while in SERVICE with pending=0x81 and mask=0xFF -> all outputs 0 immediately, mask=0x00. After release, no request until the mask is rewritten and new edges arrive.
